// File: rtl/bar_drain_if.sv
// Bundle between bar_drain, its BAR memory port and the downstream stream consumer.
interface bar_drain_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic              write_en_bar;
    logic [DATA_W-1:0] data_in_bar;
    logic [ADDR_W-1:0] addr_bar;
    logic [DATA_W-1:0] data_out_bar;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output write_en_bar, data_in_bar, addr_bar, m_valid, m_data, m_last,
        input  data_out_bar, m_ready
    );

    modport slave (
        input  write_en_bar, data_in_bar, addr_bar, m_valid, m_data, m_last,
        output data_out_bar, m_ready
    );
endinterface

// File: rtl/bar_drain.sv
// Streams DEPTH consecutive words from a 1-cycle-latency BAR read port onto a
// valid/ready stream, with a last marker and a done handshake back to start.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | issuing reads and streaming words out
// DONE   | transfer complete, waiting for start to drop
module bar_drain #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int BASE   = 0,
    parameter int DEPTH  = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    bar_drain_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int                IDX_W   = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0]  DEPTH_I = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_I  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rd_idx;
    logic [ADDR_W-1:0] addr_q;
    logic              in_flight, in_flight_last;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              run, issue, pop, push, credit, head_last, valid;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (pop && head_last) state_nxt = S_DONE;
            S_DONE:  if (!start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        done = (state == S_DONE);
        run  = (state == S_RUN);
    end

    assign valid     = (fifo_cnt != 2'd0);
    assign head_last = fifo_last[rd_ptr];
    assign pop       = valid && bus.m_ready;
    assign push      = in_flight;
    // Space must be reserved for the read still in the memory pipeline.
    assign credit    = ({1'b0, fifo_cnt} + {2'b00, in_flight} - {2'b00, pop}) < 3'd2;
    assign issue     = run && (rd_idx < DEPTH_I) && credit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_idx         <= '0;
            addr_q         <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            fifo_data[0]   <= '0;
            fifo_data[1]   <= '0;
            fifo_last      <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            fifo_cnt       <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                addr_q <= BASE_A;
                rd_idx <= '0;
            end else if (issue) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx != LAST_I) addr_q <= addr_q + 1'b1;
            end
            in_flight      <= issue;
            in_flight_last <= (rd_idx == LAST_I);
            if (push) begin
                fifo_data[wr_ptr] <= bus.data_out_bar;
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.write_en_bar = 1'b0;
    assign bus.data_in_bar  = '0;
    assign bus.addr_bar     = addr_q;
    assign bus.m_valid      = valid;
    assign bus.m_data       = valid ? fifo_data[rd_ptr] : '0;
    assign bus.m_last       = valid && head_last;
endmodule

// File: tb/tb_bar_drain.sv
// Directed bench for bar_drain: timing table for a full-rate transfer plus
// sequences for backpressure, mid-transfer reset, held start and a short window.
module tb_bar_drain;
    logic clk = 1'b0;
    logic rst_n, start1, start2, done1, done2;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bar_drain_if #(.DATA_W(64), .ADDR_W(32)) bus1();
    bar_drain_if #(.DATA_W(64), .ADDR_W(32)) bus2();

    bar_drain #(.DATA_W(64), .ADDR_W(32), .BASE(0), .DEPTH(128)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .done(done1), .bus(bus1));
    bar_drain #(.DATA_W(64), .ADDR_W(32), .BASE(64), .DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .done(done2), .bus(bus2));

    logic [63:0] mem [256];
    always @(posedge clk) begin
        bus1.data_out_bar <= mem[bus1.addr_bar[7:0]];
        bus2.data_out_bar <= mem[bus2.addr_bar[7:0]];
    end

    logic [63:0] rx[$];
    logic        rx_last[$];
    int          rx_cyc[$];
    logic [63:0] rx2[$];
    logic        rx2_last[$];
    int side_err = 0, addr_err = 0, stable_err = 0, addr2_err = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] stall_data;
    logic        stall_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (bus1.write_en_bar !== 1'b0 || bus1.data_in_bar !== 64'd0) side_err++;
            if (bus2.write_en_bar !== 1'b0 || bus2.data_in_bar !== 64'd0) side_err++;
            if (bus1.addr_bar > 32'd127) addr_err++;
            if (bus2.addr_bar > 32'd67) addr2_err++;
            if (stall_prev && !(bus1.m_valid && bus1.m_data === stall_data && bus1.m_last === stall_last))
                stable_err++;
            stall_prev = bus1.m_valid && !bus1.m_ready;
            stall_data = bus1.m_data;
            stall_last = bus1.m_last;
            if (bus1.m_valid && bus1.m_ready) begin
                rx.push_back(bus1.m_data);
                rx_last.push_back(bus1.m_last);
                rx_cyc.push_back(cyc);
            end
            if (bus2.m_valid && bus2.m_ready) begin
                rx2.push_back(bus2.m_data);
                rx2_last.push_back(bus2.m_last);
            end
        end
    end

    typedef struct {
        int          k;
        logic        valid;
        logic [63:0] data;
        logic        last;
        logic        done;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx.delete();
        rx_last.delete();
        rx_cyc.delete();
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input int limit, input bit rnd);
        int n;
        n = 0;
        while (!done1 && n < limit) begin
            if (rnd) bus1.m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus1.m_ready = 1'b1;
        if (!done1) chk("done_timeout", {63'd0, done1}, 64'd1);
    endtask

    task automatic chk_seq1(input string name);
        chk({name, "_count"}, 64'(rx.size()), 64'd128);
        for (int i = 0; i < rx.size() && i < 128; i++) begin
            chk({name, "_data"}, rx[i], mem[i]);
            chk({name, "_last"}, {63'd0, rx_last[i]}, {63'd0, i == 127});
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_done"},  {63'd0, done1},             64'd0);
        chk({name, "_valid"}, {63'd0, bus1.m_valid},      64'd0);
        chk({name, "_last"},  {63'd0, bus1.m_last},       64'd0);
        chk({name, "_data"},  bus1.m_data,                64'd0);
        chk({name, "_addr"},  {32'd0, bus1.addr_bar},     64'd0);
        chk({name, "_we"},    {63'd0, bus1.write_en_bar}, 64'd0);
        chk({name, "_din"},   bus1.data_in_bar,           64'd0);
    endtask

    initial begin
        int j, n;
        for (int i = 0; i < 256; i++) mem[i] = 64'h0101_0101_0101_0101 * 64'(i);

        // cycle offset after start edge t | valid data last done addr
        tbl[0] = '{0,   1'b0, 64'd0,    1'b0, 1'b0, 32'd0};
        tbl[1] = '{1,   1'b0, 64'd0,    1'b0, 1'b0, 32'd1};
        tbl[2] = '{2,   1'b1, mem[0],   1'b0, 1'b0, 32'd2};
        tbl[3] = '{3,   1'b1, mem[1],   1'b0, 1'b0, 32'd3};
        tbl[4] = '{50,  1'b1, mem[48],  1'b0, 1'b0, 32'd50};
        tbl[5] = '{127, 1'b1, mem[125], 1'b0, 1'b0, 32'd127};
        tbl[6] = '{128, 1'b1, mem[126], 1'b0, 1'b0, 32'd127};
        tbl[7] = '{129, 1'b1, mem[127], 1'b1, 1'b0, 32'd127};
        tbl[8] = '{130, 1'b0, 64'd0,    1'b0, 1'b1, 32'd127};

        rst_n = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        bus1.m_ready = 1'b0;
        bus2.m_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // full-rate transfer against the timing table
        clear_rx();
        bus1.m_ready = 1'b1;
        start1 = 1'b1;
        j = 0;
        for (int k = 0; k <= 130; k++) begin
            tick();
            if (k == 0) start1 = 1'b0;
            if (j < 9 && tbl[j].k == k) begin
                chk($sformatf("tbl%0d_valid", k), {63'd0, bus1.m_valid}, {63'd0, tbl[j].valid});
                chk($sformatf("tbl%0d_data", k),  bus1.m_data,           tbl[j].data);
                chk($sformatf("tbl%0d_last", k),  {63'd0, bus1.m_last},  {63'd0, tbl[j].last});
                chk($sformatf("tbl%0d_done", k),  {63'd0, done1},        {63'd0, tbl[j].done});
                chk($sformatf("tbl%0d_addr", k),  {32'd0, bus1.addr_bar}, {32'd0, tbl[j].addr});
                j++;
            end
        end
        chk_seq1("full");
        for (int i = 1; i < rx_cyc.size(); i++)
            if (rx_cyc[i] - rx_cyc[i-1] != 1) chk("full_gap", 64'(rx_cyc[i] - rx_cyc[i-1]), 64'd1);
        tick();
        chk("idle_after_full", {63'd0, done1}, 64'd0);

        // random backpressure
        clear_rx();
        pulse_start1();
        wait_done1(3000, 1'b1);
        chk_seq1("rand");
        tick();
        tick();

        // ten-cycle stall with word 5 at the head
        clear_rx();
        pulse_start1();
        n = 0;
        while (rx.size() < 5 && n < 100) begin
            tick();
            n++;
        end
        bus1.m_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            chk("stall_valid", {63'd0, bus1.m_valid}, 64'd1);
            chk("stall_data", bus1.m_data, mem[5]);
            tick();
        end
        bus1.m_ready = 1'b1;
        wait_done1(300, 1'b0);
        chk_seq1("stall");
        if (rx_cyc.size() >= 8) begin
            chk("stall_b2b_6", 64'(rx_cyc[6] - rx_cyc[5]), 64'd1);
            chk("stall_b2b_7", 64'(rx_cyc[7] - rx_cyc[6]), 64'd1);
        end
        tick();
        tick();

        // reset at beat 40, then restart from word 0
        clear_rx();
        pulse_start1();
        n = 0;
        while (rx.size() < 40 && n < 200) begin
            tick();
            n++;
        end
        chk("pre_reset_beats", 64'(rx.size()), 64'd40);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        tick();
        chk("post_reset_valid", {63'd0, bus1.m_valid}, 64'd0);
        clear_rx();
        pulse_start1();
        wait_done1(300, 1'b0);
        chk_seq1("restart");
        tick();
        tick();

        // start held high: exactly one transfer until it drops
        clear_rx();
        start1 = 1'b1;
        tick();
        wait_done1(300, 1'b0);
        for (int s = 0; s < 20; s++) tick();
        chk("held_done", {63'd0, done1}, 64'd1);
        chk("held_count", 64'(rx.size()), 64'd128);
        chk("held_valid", {63'd0, bus1.m_valid}, 64'd0);
        start1 = 1'b0;
        tick();
        chk("held_release_done", {63'd0, done1}, 64'd0);
        clear_rx();
        pulse_start1();
        wait_done1(300, 1'b0);
        chk_seq1("second");
        tick();

        // BASE=64, DEPTH=4 instance
        bus2.m_ready = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 50) begin
            tick();
            n++;
        end
        chk("w4_done", {63'd0, done2}, 64'd1);
        chk("w4_count", 64'(rx2.size()), 64'd4);
        for (int i = 0; i < rx2.size() && i < 4; i++) begin
            chk("w4_data", rx2[i], mem[64 + i]);
            chk("w4_last", {63'd0, rx2_last[i]}, {63'd0, i == 3});
        end
        chk("w4_addr_end", {32'd0, bus2.addr_bar}, 64'd67);

        chk("bar_write_side", 64'(side_err), 64'd0);
        chk("addr_range", 64'(addr_err), 64'd0);
        chk("addr2_range", 64'(addr2_err), 64'd0);
        chk("stall_stability", 64'(stable_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bar_drain.md
# bar_drain

Read-side streaming engine for a BAR memory port. On `start` it reads `DEPTH` consecutive 64-bit words from a BAR memory and emits them in order on a valid/ready stream with a last marker, then reports `done`. It sits on the result BAR (`mem` instance written by `linear`) and hands results to the next stage or host interface. It absorbs stream backpressure without losing, duplicating or reordering words.

## Interface
- `DATA_W`, 64: BAR and stream data width.
- `ADDR_W`, 32: BAR address width; addresses are word indices.
- `BASE`, 0: word address of the first word read.
- `DEPTH`, 128: number of words per transfer; legal range 1..2^16.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  level; sampled only in IDLE.
- `done`  out  1  high in DONE state.
- `write_en_bar`  out  1  BAR write enable; constant 0.
- `data_in_bar`  out  DATA_W  BAR write data; constant 0.
- `addr_bar`  out  ADDR_W  BAR word address, registered.
- `data_out_bar`  in  DATA_W  BAR read data; holds mem[addr_bar sampled at edge e] after edge e (1-cycle registered read).
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_W  stream word.
- `m_last`  out  1  high with the word from `BASE+DEPTH-1`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 at edge t -> RUN; `addr_bar`<=`BASE`, read index<=0.
- RUN: issue one read per cycle while buffer credit exists; read data captured into a 2-entry output FIFO; FIFO head drives `m_data`/`m_last`, `m_valid` = FIFO non-empty.
- Credit rule: issue allowed when (FIFO count + reads in flight − pop this cycle) < 2. FIFO must never overflow; no word dropped or read twice.
- `addr_bar` = `BASE` + read index; increments on each issue; after the last issue it holds `BASE+DEPTH-1`. No wrap: index width clog2(DEPTH)+1, issue stops at DEPTH.
- Handshake: word transfers when `m_valid`&&`m_ready` at an edge. While `m_valid`=1 and `m_ready`=0, `m_data`/`m_last` are stable.
- `m_valid` never drops without a handshake.
- RUN -> DONE on the edge that transfers the `m_last` word.
- DONE: `done`=1; stays until `start`=0 is sampled, then -> IDLE (`done`=0). Held `start` yields exactly one transfer.
- `start` changes in RUN are ignored.
- `DEPTH`=1: single word with `m_last`=1.

## Timing
- Reset (`rst_n`=0 at an edge, any state, including mid-transfer): state IDLE; `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `addr_bar`=0, `write_en_bar`=0, `data_in_bar`=0; FIFO and in-flight reads discarded.
- Start latency: `start` sampled at edge t -> `addr_bar`=`BASE` after t; memory samples at t+1; word 0 captured, `m_valid`=1 after t+2.
- Throughput: with `m_ready` held 1, one word per cycle; DEPTH words on consecutive cycles t+2 .. t+DEPTH+1.
- `done` rises after the edge transferring the last word (with `m_ready`=1 throughout: after edge t+DEPTH+2... precisely the edge following t+DEPTH+1 capture of handshake, i.e. `done`=1 from t+DEPTH+2).
- Backpressure: reads in flight plus FIFO ≤ 2. After `m_ready` returns to 1, streaming resumes at 1 word/cycle with no bubble.

## Test plan
- DEPTH=128, BASE=0, mem[i]=64'h0101_0101_0101_0101*i, `m_ready`=1: 128 consecutive beats, data i at beat i, `m_last` only on beat 127, `done`=1 from t+130.
- Same memory, `m_ready` random 50%: received sequence equals mem[0..127] exactly; `addr_bar` never exceeds 127; `write_en_bar` always 0.
- `m_ready`=0 for 10 cycles after beat 5: `m_valid`=1, `m_data`=mem[5] stable for all 10 cycles; next beats 5,6,7 back-to-back after release.
- `rst_n`=0 for one edge at beat 40: all outputs at reset values next cycle; new `start` restarts from mem[0].
- `start` held 1 throughout: one transfer, `done` stays 1; drop `start` -> IDLE; raise again -> second identical transfer.
- BASE=64, DEPTH=4: beats mem[64..67], `m_last` on mem[67], `addr_bar` ends at 67.
